// File: rtl/seg_pkg.sv
// Shared glyph constants, FSM state type and sizing helper for the
// seven-segment bus reader (alternate glyphs used with SEG_READER_ALT_GLYPH_EN).
package seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0011000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_7_ALT = 7'b1011000;
    localparam logic [6:0] GLYPH_9_ALT = 7'b0010000;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        COMMIT,
        HOLD
    } seg_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Maps an active-low seven-segment pattern to its hex nibble.
// SEG_READER_ALT_GLYPH_EN adds the alternate 7 and 9 shapes.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        unique case (seg)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
`ifdef SEG_READER_ALT_GLYPH_EN
            GLYPH_7_ALT: nibble = 4'h7;
            GLYPH_9_ALT: nibble = 4'h9;
`endif
            GLYPH_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_pattern_reader.sv
// Seven-segment bus receiver: debounces {digit_en, seg_in}, decodes settled
// glyphs into per-digit shadow nibbles. Optional macro: SEG_READER_ALT_GLYPH_EN.
module seg_pattern_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [6:0]                    seg_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [4*NUM_DIGITS-1:0]       value_out,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic                          upd_valid,
    output logic [idx_w(NUM_DIGITS)-1:0]  upd_idx,
    output logic [3:0]                    upd_nibble,
    output logic                          err
);

    localparam int IW = idx_w(NUM_DIGITS);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 7;

    logic [SW-1:0]         samp;
    logic [SW-1:0]         samp_prev;
    logic [CW-1:0]         cnt;
    seg_state_t            state;

    logic [NUM_DIGITS-1:0] s_en;
    logic [6:0]            s_seg;
    logic                  changed;
    logic                  onehot;
    logic                  settled;
    logic [IW-1:0]         sel;
    logic                  g_legal;
    logic                  g_blank;
    logic [3:0]            g_nib;

    assign s_en    = samp[SW-1:7];
    assign s_seg   = samp[6:0];
    assign changed = (samp != samp_prev);
    assign onehot  = (s_en != '0) && ((s_en & (s_en - 1'b1)) == '0);
    assign settled = (cnt + 1'b1) == CW'(STABLE_CYCLES);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s_en[i]) sel = IW'(i);
        end
    end

    seg_glyph_decode u_dec (
        .seg    (s_seg),
        .legal  (g_legal),
        .blank  (g_blank),
        .nibble (g_nib)
    );

    // The commit action is taken on the edge that leaves COUNT, so the
    // pulse lines up with the single cycle spent in COMMIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            samp        <= '0;
            samp_prev   <= '0;
            cnt         <= '0;
            state       <= IDLE;
            value_out   <= '0;
            digit_valid <= '0;
            upd_valid   <= 1'b0;
            upd_idx     <= '0;
            upd_nibble  <= '0;
            err         <= 1'b0;
        end else begin
            samp      <= {digit_en, seg_in};
            samp_prev <= samp;
            upd_valid <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (changed) begin
                        state <= COUNT;
                        cnt   <= CW'(1);
                    end
                end
                COUNT: begin
                    if (changed) begin
                        cnt <= CW'(1);
                    end else if (settled) begin
                        state <= COMMIT;
                        cnt   <= '0;
                        if (s_en != '0) begin
                            if (!onehot) begin
                                err <= 1'b1;
                            end else if (g_blank) begin
                                digit_valid[sel] <= 1'b0;
                            end else if (g_legal) begin
                                value_out[4*sel +: 4] <= g_nib;
                                digit_valid[sel]      <= 1'b1;
                                upd_valid             <= 1'b1;
                                upd_idx               <= sel;
                                upd_nibble            <= g_nib;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A change landing during COMMIT starts a new window at once.
                COMMIT: begin
                    if (changed) begin
                        state <= COUNT;
                        cnt   <= CW'(1);
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state <= COUNT;
                        cnt   <= CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Randomized bench for seg_pattern_reader against a run-length reference model.
// Define SEG_READER_ALT_GLYPH_EN for both bench and RTL to test the alternates.
module tb_seg_pattern_reader;

    localparam int ND = 6;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [6:0]    seg_in;
    logic [ND-1:0] digit_en;
    wire [4*ND-1:0] value_out;
    wire [ND-1:0]   digit_valid;
    wire            upd_valid;
    wire [2:0]      upd_idx;
    wire [3:0]      upd_nibble;
    wire            err;

    int total = 0;
    int bad   = 0;

    logic [6:0]     gl [16];
    logic [ND+6:0]  m_last;
    int             m_run;
    logic [4*ND-1:0] m_val;
    logic [ND-1:0]  m_dv;
    logic           m_uv;
    logic           m_err;
    logic [2:0]     m_ui;
    logic [3:0]     m_un;
    logic           seen_upd;
    logic           seen_err;
    logic [3:0]     seen_nib;

    seg_pattern_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .seg_in      (seg_in),
        .digit_en    (digit_en),
        .value_out   (value_out),
        .digit_valid (digit_valid),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_nibble  (upd_nibble),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] sg);
        int n;
        n = -1;
        for (int i = 0; i < 16; i++)
            if (gl[i] == sg) n = i;
`ifdef SEG_READER_ALT_GLYPH_EN
        if (sg == 7'b1011000) n = 7;
        if (sg == 7'b0010000) n = 9;
`endif
        return n;
    endfunction

    task automatic model_reset();
        m_last = '0;
        m_run  = 1000;
        m_val  = '0;
        m_dv   = '0;
        m_uv   = 1'b0;
        m_err  = 1'b0;
        m_ui   = '0;
        m_un   = '0;
    endtask

    task automatic apply(input logic [ND+6:0] p);
        logic [ND-1:0] en;
        logic [6:0]    sg;
        int            n;
        int            d;
        en = p[ND+6:7];
        sg = p[6:0];
        d  = 0;
        for (int i = 0; i < ND; i++)
            if (en[i]) d = i;
        if (en == '0) begin
            m_err = 1'b0;
        end else if ($countones(en) != 1) begin
            m_err = 1'b1;
        end else if (sg == 7'h7f) begin
            m_dv[d] = 1'b0;
        end else begin
            n = lookup(sg);
            if (n < 0) begin
                m_err = 1'b1;
            end else begin
                m_val[4*d +: 4] = n[3:0];
                m_dv[d] = 1'b1;
                m_uv    = 1'b1;
                m_ui    = d[2:0];
                m_un    = n[3:0];
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".val"}, 32'(value_out), 32'(m_val));
        chk({tag, ".dv"},  32'(digit_valid), 32'(m_dv));
        chk({tag, ".upd"}, 32'(upd_valid), 32'(m_uv));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".idx"}, 32'(upd_idx), 32'(m_ui));
        chk({tag, ".nib"}, 32'(upd_nibble), 32'(m_un));
    endtask

    // A pattern commits once it has been captured S edges in a row after
    // a change; the pulse shows in the cycle after the following edge.
    task automatic tick(input logic [ND-1:0] en, input logic [6:0] sg,
                        input string tag);
        digit_en = en;
        seg_in   = sg;
        @(posedge clk);
        m_uv  = 1'b0;
        m_err = 1'b0;
        if (m_run == S) apply(m_last);
        if ({en, sg} != m_last) begin
            m_last = {en, sg};
            m_run  = 1;
        end else if (m_run < 1000) begin
            m_run++;
        end
        #1;
        if (upd_valid) begin
            seen_upd = 1'b1;
            seen_nib = upd_nibble;
        end
        if (err) seen_err = 1'b1;
        cmp_all(tag);
    endtask

    task automatic hold(input logic [ND-1:0] en, input logic [6:0] sg,
                        input int n, input string tag);
        seen_upd = 1'b0;
        seen_err = 1'b0;
        for (int i = 0; i < n; i++) tick(en, sg, tag);
    endtask

    task automatic pulse_reset();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        cmp_all("rst_async");
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        gl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        resetn   = 1'b0;
        digit_en = '0;
        seg_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp_all("reset");
        @(negedge clk);
        resetn = 1'b1;

        hold(6'b000100, 7'b0100100, 8, "d2_glyph2");
        chk("d2_pulse", 32'(seen_upd), 1);
        chk("d2_nib", 32'(value_out[11:8]), 2);
        chk("d2_dv", 32'(digit_valid), 32'b000100);

        hold(6'b000001, 7'b0110000, 3, "glitch_a");
        chk("glitch_nopulse", 32'(seen_upd), 0);
        hold(6'b000001, 7'b1111001, 8, "glitch_b");
        chk("glitch_pulse", 32'(seen_upd), 1);
        chk("glitch_nib", 32'(seen_nib), 1);

        hold(6'b100000, 7'b1010101, 8, "illegal");
        chk("illegal_err", 32'(seen_err), 1);
        chk("illegal_dv5", 32'(digit_valid[5]), 0);

        hold(6'b000011, 7'b1111001, 8, "multi_en");
        chk("multi_err", 32'(seen_err), 1);
        chk("multi_noupd", 32'(seen_upd), 0);

        hold(6'b000100, 7'b1111111, 8, "blank");
        chk("blank_dv2", 32'(digit_valid[2]), 0);
        chk("blank_nib", 32'(value_out[11:8]), 2);
        chk("blank_noupd", 32'(seen_upd), 0);

        hold(6'b001000, 7'b0000000, 3, "mid_win");
        pulse_reset();
        hold(6'b001000, 7'b0000000, 4, "post_rst_a");
        chk("post_rst_nopulse", 32'(seen_upd), 0);
        hold(6'b001000, 7'b0000000, 4, "post_rst_b");
        chk("post_rst_pulse", 32'(seen_upd), 1);

        hold(6'b000010, 7'b1011000, 8, "alt7");
`ifdef SEG_READER_ALT_GLYPH_EN
        chk("alt7_nib", 32'(seen_nib), 7);
`else
        chk("alt7_err", 32'(seen_err), 1);
`endif

        for (int r = 0; r < 300; r++) begin
            logic [ND-1:0] en;
            logic [6:0]    sg;
            int            k;
            k  = $urandom_range(0, 9);
            en = ND'(1) << $urandom_range(0, ND - 1);
            sg = gl[$urandom_range(0, 15)];
            if (k == 6) sg = 7'h7f;
            if (k == 7) sg = 7'($urandom);
            if (k == 8) en = '0;
            if (k == 9) en = ND'($urandom);
            hold(en, sg, $urandom_range(1, S + 3), "rand");
            if ($urandom_range(0, 40) == 0) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_pattern_reader.md
Name: seg_pattern_reader

Overview:
- Receiver end of the team's multiplexed seven-segment display bus. Samples active-low segment lines plus per-digit enables, filters transients, and maps each stable glyph back to its 4-bit hex value.
- Keeps a per-digit shadow register of the displayed value and emits one update pulse per newly settled digit.
- Used as a display monitor/self-check alongside the hex display drivers, and to read captured displays back into the datapath.

Parameters:
- NUM_DIGITS, 6, number of digit positions on the bus (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a glyph is accepted (2..255).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- seg_in  in  7  active-low segments; bit0=a … bit6=g.
- digit_en  in  NUM_DIGITS  active-high digit select; exactly one bit set when a digit is driven.
- value_out  out  4*NUM_DIGITS  shadow nibbles; digit i occupies [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i currently holds an accepted non-blank glyph.
- upd_valid  out  1  single-cycle pulse on each accepted legal glyph.
- upd_idx  out  $clog2(NUM_DIGITS)  digit index for upd_valid.
- upd_nibble  out  4  decoded value for upd_valid.
- err  out  1  single-cycle pulse on a settled illegal glyph or non-one-hot digit_en.

Behaviour:
- Reset (async, resetn=0): all outputs 0; sample register, counter and FSM cleared. Reset mid-window discards the pending glyph, with no pulse.
- Input stage: {digit_en, seg_in} is registered each clock into samp; samp_prev holds the previous samp.
- FSM states and transitions:
  - IDLE → COUNT when samp != samp_prev; counter loads 1.
  - COUNT: if samp == samp_prev, counter increments. On reaching STABLE_CYCLES → COMMIT. If samp changes, counter reloads 1 and stays in COUNT.
  - COMMIT (exactly one cycle) → HOLD.
  - HOLD: stays until samp != samp_prev, then → COUNT with counter 1.
- Net latency: inputs change before edge k and are held. The first capturing edge is k. The COMMIT action is registered so that upd_valid/err are high during the cycle after edge k+STABLE_CYCLES. With STABLE_CYCLES=4, the pulse is high for the cycle after edge k+4.
- COMMIT action, evaluated on samp:
  - digit_en == 0: no action, no pulse.
  - digit_en not one-hot: err=1; shadow registers unchanged.
  - seg == 7'b1111111 (blank): digit_valid[i] cleared, value_out nibble retained, no pulse.
  - Legal glyph: nibble written, digit_valid[i]=1, upd_valid=1 with upd_idx=i and upd_nibble.
  - Any other pattern: err=1; slot unchanged.
- Glyph table (seg_in → nibble): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F.
- Re-accepting an unchanged glyph still pulses upd_valid. Each settled window commits exactly once.
- upd_idx and upd_nibble hold their last values when upd_valid=0. upd_valid and err are never both 1.

Optional Feature:
- Macro SEG_READER_ALT_GLYPH_EN.
- Defined: additionally accept alternate glyphs 1011000→7 (segment f lit) and 0010000→9 (segment d lit).
- Undefined: both patterns are illegal and raise err.

Decomposition:
- Package seg_pkg:
  - glyph constants GLYPH_0..GLYPH_F, GLYPH_BLANK, and alternate glyph constants;
  - FSM state enum {IDLE, COUNT, COMMIT, HOLD};
  - digit index width helper.
- Sub-module seg_glyph_decode: combinational seg[6:0] → {legal, blank, nibble[3:0]}, honouring SEG_READER_ALT_GLYPH_EN.
- seg_pattern_reader instantiates seg_glyph_decode and contains the sampling, counter, FSM and shadow registers.

Test Plan:
- Reset, then hold digit_en=6'b000100 and seg_in=0100100 → one upd_valid pulse with upd_idx=2 and upd_nibble=2, in the cycle after edge k+4; value_out[11:8]=2 and digit_valid=6'b000100.
- Glitch: seg_in=0110000 for 3 cycles, then 1111001 held, digit 0 → no pulse for the first pattern; a single pulse with nibble=1 after the second settles.
- Illegal glyph 1010101 held on digit 5 → one err pulse; value_out[23:20] and digit_valid[5] unchanged.
- digit_en=6'b000011 held with a legal glyph → err pulse; no shadow write.
- Blank 1111111 held on a valid digit 2 holding 2 → digit_valid[2]=0, value_out[11:8] still 2, no upd_valid.
- Assert resetn=0 at cycle 2 of a COUNT window → all outputs 0 immediately, and no pulse after release until a fresh STABLE_CYCLES window completes.
- With the macro defined, 1011000 on digit 1 → upd_nibble=7; without the macro → err.
